pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush/forwarding controller for the 5-stage RV32I pipeline (F,D,E,M,W).

---
 rtl/pipeline_hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for a 5-stage RV32I pipeline.
// Handles load-use, redirect, the data-memory handshake, the reset flush and the memory timeout.
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned RST_FLUSH = 2,
  parameter int unsigned CNT_W     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs1_D,
  input  logic [4:0] rs2_D,
  input  logic [4:0] rs1_E,
  input  logic [4:0] rs2_E,
  input  logic [4:0] rd_E,
  input  logic       we_reg_E,
  input  logic [1:0] wb_ctrl_E,
  input  logic [4:0] rd_M,
  input  logic       we_reg_M,
  input  logic [4:0] rd_W,
  input  logic       we_reg_W,
  input  logic       redirect_E,
  input  logic       mem_op_M,
  input  logic       mem_ready,
  output logic       stall_F,
  output logic       stall_D,
  output logic       stall_E,
  output logic       stall_M,
  output logic       flush_D,
  output logic       flush_E,
  output logic       bubble_W,
  output logic [1:0] fwd_a_E,
  output logic [1:0] fwd_b_E,
  output logic       mem_req,
  output logic       mem_err
);

  typedef enum logic [1:0] {RST_SEQ, IDLE, MEM_WAIT, MEM_ERR} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_FLUSH - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             load_use;

  assign load_use = (wb_ctrl_E == 2'b01) && we_reg_E && (rd_E != 5'd0) &&
                    ((rd_E == rs1_D) || (rd_E == rs2_D));

  // Operand bypass; M is the younger result so it wins, x0 is never bypassed.
  assign fwd_a_E = (we_reg_M && (rd_M != 5'd0) && (rd_M == rs1_E)) ? 2'b10 :
                   (we_reg_W && (rd_W != 5'd0) && (rd_W == rs1_E)) ? 2'b01 : 2'b00;
  assign fwd_b_E = (we_reg_M && (rd_M != 5'd0) && (rd_M == rs2_E)) ? 2'b10 :
                   (we_reg_W && (rd_W != 5'd0) && (rd_W == rs2_E)) ? 2'b01 : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_SEQ;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall_F  = 1'b0;
    stall_D  = 1'b0;
    stall_E  = 1'b0;
    stall_M  = 1'b0;
    flush_D  = 1'b0;
    flush_E  = 1'b0;
    bubble_W = 1'b0;
    mem_req  = 1'b0;
    mem_err  = 1'b0;
    case (state)
      RST_SEQ: begin
        stall_F = 1'b1;
        flush_D = 1'b1;
        flush_E = 1'b1;
        if (cnt == RST_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      IDLE: begin
        mem_req = mem_op_M;
        // A memory miss freezes the pipe this cycle and masks both hazards.
        if (mem_op_M && !mem_ready) begin
          stall_F  = 1'b1;
          stall_D  = 1'b1;
          stall_E  = 1'b1;
          stall_M  = 1'b1;
          bubble_W = 1'b1;
          state_nx = MEM_WAIT;
          cnt_nx   = '0;
        end else if (redirect_E) begin
          flush_D = 1'b1;
          flush_E = 1'b1;
        end else if (load_use) begin
          stall_F = 1'b1;
          stall_D = 1'b1;
          flush_E = 1'b1;
        end
      end
      MEM_WAIT: begin
        mem_req = 1'b1;
        cnt_nx  = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
        if (mem_ready) begin
          state_nx = IDLE;
        end else begin
          stall_F  = 1'b1;
          stall_D  = 1'b1;
          stall_E  = 1'b1;
          stall_M  = 1'b1;
          bubble_W = 1'b1;
          if (cnt == TO_LAST) state_nx = MEM_ERR;
        end
      end
      MEM_ERR: begin
        mem_err  = 1'b1;
        stall_F  = 1'b1;
        stall_D  = 1'b1;
        stall_E  = 1'b1;
        stall_M  = 1'b1;
        bubble_W = 1'b1;
      end
      default: state_nx = RST_SEQ;
    endcase
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table for the combinational hazard/forward
// decode in IDLE, plus hand sequences for reset flush, memory wait, timeout and async abort.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E;
    logic       we_E;
    logic [1:0] wb_E;
    logic [4:0] rd_M;
    logic       we_M;
    logic [4:0] rd_W;
    logic       we_W, redir, mop, mrdy;
    logic [12:0] exp;  // {sF,sD,sE,sM, fD,fE, bW, fa[1:0], fb[1:0], req, err}
  } vec_t;

  logic       clk, rst_n;
  logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic       we_reg_E, we_reg_M, we_reg_W, redirect_E, mem_op_M, mem_ready;
  logic [1:0] wb_ctrl_E, fwd_a_E, fwd_b_E;
  logic       stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, bubble_W, mem_req, mem_err;
  logic [12:0] outv;

  int total = 0;
  int bad   = 0;

  localparam logic [12:0] E_ZERO  = 13'b0000_00_0_00_00_0_0;
  localparam logic [12:0] E_RST   = 13'b1000_11_0_00_00_0_0;
  localparam logic [12:0] E_LU    = 13'b1100_01_0_00_00_0_0;
  localparam logic [12:0] E_REDIR = 13'b0000_11_0_00_00_0_0;
  localparam logic [12:0] E_MSTL  = 13'b1111_00_1_00_00_1_0;
  localparam logic [12:0] E_REQ   = 13'b0000_00_0_00_00_1_0;
  localparam logic [12:0] E_ERR   = 13'b1111_00_1_00_00_0_1;

  pipeline_hazard_ctrl #(.TIMEOUT(16), .RST_FLUSH(2), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .we_reg_E(we_reg_E), .wb_ctrl_E(wb_ctrl_E),
    .rd_M(rd_M), .we_reg_M(we_reg_M), .rd_W(rd_W), .we_reg_W(we_reg_W),
    .redirect_E(redirect_E), .mem_op_M(mem_op_M), .mem_ready(mem_ready),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .bubble_W(bubble_W),
    .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E), .mem_req(mem_req), .mem_err(mem_err)
  );

  assign outv = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, bubble_W,
                 fwd_a_E, fwd_b_E, mem_req, mem_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rs1_D = v.rs1_D; rs2_D = v.rs2_D; rs1_E = v.rs1_E; rs2_E = v.rs2_E;
    rd_E = v.rd_E; we_reg_E = v.we_E; wb_ctrl_E = v.wb_E;
    rd_M = v.rd_M; we_reg_M = v.we_M; rd_W = v.rd_W; we_reg_W = v.we_W;
    redirect_E = v.redir; mem_op_M = v.mop; mem_ready = v.mrdy;
  endtask

  // Pulse reset at a negedge, release, and wait out the reset flush.
  task automatic reset_and_settle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  vec_t tbl[$];
  vec_t v;
  vec_t lu;

  initial begin
    // ---- vector table, all applied in IDLE ----
    v = '0;                                                   v.exp = E_ZERO;  tbl.push_back(v);
    v = '0; v.wb_E = 2'b01; v.we_E = 1; v.rd_E = 5; v.rs2_D = 5; v.rs1_D = 3;
                                                              v.exp = E_LU;    tbl.push_back(v);
    v = '0; v.wb_E = 2'b01; v.we_E = 1; v.rd_E = 0; v.rs1_D = 0; v.rs2_D = 0;
                                                              v.exp = E_ZERO;  tbl.push_back(v);
    v = '0; v.wb_E = 2'b01; v.we_E = 1; v.rd_E = 9; v.rs1_D = 9;
                                                              v.exp = E_LU;    tbl.push_back(v);
    v = '0; v.wb_E = 2'b10; v.we_E = 1; v.rd_E = 5; v.rs2_D = 5;
                                                              v.exp = E_ZERO;  tbl.push_back(v);
    v = '0; v.wb_E = 2'b01; v.we_E = 0; v.rd_E = 5; v.rs2_D = 5;
                                                              v.exp = E_ZERO;  tbl.push_back(v);
    v = '0; v.wb_E = 2'b01; v.we_E = 1; v.rd_E = 5; v.rs2_D = 5; v.redir = 1;
                                                              v.exp = E_REDIR; tbl.push_back(v);
    v = '0; v.redir = 1;                                      v.exp = E_REDIR; tbl.push_back(v);
    v = '0; v.rd_M = 7; v.rd_W = 7; v.rs1_E = 7; v.we_M = 1; v.we_W = 1;
                                                              v.exp = 13'b0000_00_0_10_00_0_0; tbl.push_back(v);
    v = '0; v.rd_M = 7; v.rd_W = 7; v.rs1_E = 7; v.we_M = 0; v.we_W = 1;
                                                              v.exp = 13'b0000_00_0_01_00_0_0; tbl.push_back(v);
    v = '0; v.rd_M = 0; v.rd_W = 0; v.rs1_E = 0; v.we_M = 1; v.we_W = 1;
                                                              v.exp = E_ZERO;  tbl.push_back(v);
    v = '0; v.rd_M = 12; v.rd_W = 12; v.rs2_E = 12; v.we_M = 1; v.we_W = 1;
                                                              v.exp = 13'b0000_00_0_00_10_0_0; tbl.push_back(v);
    v = '0; v.rd_M = 4; v.rd_W = 4; v.rs1_E = 4; v.rs2_E = 4; v.we_M = 0; v.we_W = 1;
                                                              v.exp = 13'b0000_00_0_01_01_0_0; tbl.push_back(v);
    v = '0; v.rd_M = 3; v.rd_W = 6; v.rs1_E = 6; v.rs2_E = 3; v.we_M = 1; v.we_W = 1;
                                                              v.exp = 13'b0000_00_0_01_10_0_0; tbl.push_back(v);
    v = '0; v.mop = 1; v.mrdy = 1;                            v.exp = E_REQ;   tbl.push_back(v);

    lu = '0; lu.wb_E = 2'b01; lu.we_E = 1; lu.rd_E = 5; lu.rs2_D = 5;

    // ---- reset and the post-reset flush window ----
    v = '0;
    drive(v);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outv, E_RST);
    rst_n = 1'b1;
    #1 check("rst_flush_cycle1", outv, E_RST);
    @(negedge clk);
    check("rst_flush_cycle2", outv, E_RST);
    @(negedge clk);
    check("rst_flush_done", outv, E_ZERO);

    // ---- table ----
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1 check($sformatf("vec%0d", i), outv, tbl[i].exp);
      @(negedge clk);
    end

    // ---- memory wait: ready low 3 cycles, then high; pending load-use masked ----
    v = lu; v.mop = 1; v.mrdy = 0;
    drive(v);
    #1 check("mw_idle_miss", outv, E_MSTL);
    @(negedge clk);
    check("mw_wait1", outv, E_MSTL);
    @(negedge clk);
    check("mw_wait2", outv, E_MSTL);
    mem_ready = 1'b1;
    #1 check("mw_release", outv, E_REQ);
    @(negedge clk);
    mem_op_M = 1'b0;
    #1 check("mw_loaduse_after", outv, E_LU);
    @(negedge clk);

    // ---- timeout into MEM_ERR, sticky until reset ----
    v = '0; v.mop = 1; v.mrdy = 0; v.redir = 1;
    drive(v);
    #1 check("to_idle_miss", outv, E_MSTL);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("to_wait%0d", i), outv, E_MSTL);
    end
    @(negedge clk);
    check("to_mem_err", outv, E_ERR);
    mem_op_M = 1'b0; mem_ready = 1'b1; redirect_E = 1'b0;
    repeat (2) @(negedge clk);
    check("to_err_sticky", outv, E_ERR);
    #2 rst_n = 1'b0;
    #1 check("to_err_cleared_by_reset", outv, E_RST);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("to_idle_after_reset", outv, E_ZERO);

    // ---- async reset mid-wait drops mem_req immediately ----
    v = '0; v.mop = 1; v.mrdy = 0;
    drive(v);
    @(negedge clk);
    check("abort_in_wait", outv, E_MSTL);
    #2 rst_n = 1'b0;
    #1 check("abort_async", outv, E_RST);
    v = '0;
    drive(v);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_recovered", outv, E_ZERO);
    reset_and_settle();
    check("final_idle", outv, E_ZERO);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
